// File: rtl/doodle_pkg.sv
// Shared definitions for the player physics block: game modes, keycodes, screen geometry.
// Pure definitions plus one combinational helper; no state, no latency.
// No flow control; everything here is consumed once per frame.
package doodle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10
  } mode_t;

  localparam logic [7:0] KEY_LEFT_A    = 8'd4;
  localparam logic [7:0] KEY_LEFT_ARR  = 8'd80;
  localparam logic [7:0] KEY_RIGHT_D   = 8'd7;
  localparam logic [7:0] KEY_RIGHT_ARR = 8'd79;
  localparam logic [7:0] KEY_FIRE      = 8'd30;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int SCREEN_CX = 320;
  localparam int SCREEN_CY = 240;

  // True when |a - b| <= tol, evaluated in 11-bit signed arithmetic
  function automatic logic withinTol(input logic signed [10:0] a,
                                     input logic signed [10:0] b,
                                     input logic [8:0] tol);
    logic signed [10:0] diff;
    diff = a - b;
    if (diff < 0) diff = -diff;
    return diff <= $signed({2'b00, tol});
  endfunction

endpackage

// File: rtl/shot_pool.sv
// Projectile slots: lowest-free-slot allocation, upward motion, retire, dropped-request pulse.
// Registered outputs, one frame after the fire request / mode sample.
// No backpressure: a fire request with every slot busy is discarded and flagged.
module shot_pool
  import doodle_pkg::*;
#(
  parameter int NUM_SHOTS  = 4,
  parameter int SHOT_SPEED = 7,
  parameter int SHOT_Y_MIN = 25
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic                      clear,
  input  logic                      run,
  input  logic                      fire,
  input  logic [9:0]                originX,
  input  logic [9:0]                originY,
  output logic [NUM_SHOTS-1:0][9:0] shot_x,
  output logic [NUM_SHOTS-1:0][9:0] shot_y,
  output logic [NUM_SHOTS-1:0]      shot_active,
  output logic                      shot_dropped
);

  localparam logic [9:0] SPEED_Y  = 10'(SHOT_SPEED);
  localparam logic [9:0] RETIRE_Y = 10'(SHOT_Y_MIN + SHOT_SPEED);
  localparam logic [9:0] HOME_X   = 10'(SCREEN_CX);
  localparam logic [9:0] HOME_Y   = 10'(SCREEN_CY);

  logic [NUM_SHOTS-1:0] grant;
  logic                 anyFree;

  // One-hot grant of the lowest slot that is idle at the start of the frame;
  // a slot retiring this frame still reads as active, so it is not reused yet
  always_comb begin
    grant = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!shot_active[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  assign anyFree = |grant;

  // Slot state: clear in IDLE, move/retire/load in PLAY, hold otherwise
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      shot_active  <= '0;
      shot_dropped <= 1'b0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        shot_x[i] <= HOME_X;
        shot_y[i] <= HOME_Y;
      end
    end else if (clear) begin
      shot_active  <= '0;
      shot_dropped <= 1'b0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        shot_x[i] <= HOME_X;
        shot_y[i] <= HOME_Y;
      end
    end else if (run) begin
      shot_dropped <= fire && !anyFree;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (shot_active[i]) begin
          shot_y[i] <= shot_y[i] - SPEED_Y;
          if (shot_y[i] <= RETIRE_Y) shot_active[i] <= 1'b0;
        end else if (fire && grant[i]) begin
          shot_x[i]      <= originX;
          shot_y[i]      <= originY;
          shot_active[i] <= 1'b1;
        end
      end
    end else begin
      shot_dropped <= 1'b0;
    end
  end

endmodule

// File: rtl/doodle_physics.sv
// Per-frame player physics: gravity, platform/floor bounce, horizontal move with wrap, shots.
// Every output is registered: reflects inputs sampled at the previous frame_clk edge.
// No backpressure; PAUSE freezes all state, IDLE parks the character and clears shots.
module doodle_physics
  import doodle_pkg::*;
#(
  parameter int NUM_PLATS   = 16,
  parameter int NUM_SHOTS   = 4,
  parameter int GRAVITY     = 1,
  parameter int JUMP_VEL    = 12,
  parameter int MAX_FALL    = 10,
  parameter int MOVE_STEP   = 2,
  parameter int SHOT_SPEED  = 7,
  parameter int DOODLE_SIZE = 6,
  parameter int X_MIN       = 25,
  parameter int X_MAX       = SCREEN_W - 1 - 25,
  parameter int Y_MAX       = SCREEN_H - 1,
  parameter int SHOT_Y_MIN  = 25,
  localparam int IDX_W      = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [1:0]                mode,
  input  logic [7:0]                keycode,
  input  logic [NUM_PLATS-1:0][8:0] plat_x,
  input  logic [NUM_PLATS-1:0][8:0] plat_y,
  input  logic [NUM_PLATS-1:0]      plat_valid,
  input  logic [8:0]                plat_half_w,
  input  logic [8:0]                plat_half_h,
  output logic [9:0]                doodle_x,
  output logic [9:0]                doodle_y,
  output logic [7:0]                doodle_vy,
  output logic                      landed,
  output logic [IDX_W-1:0]          landed_idx,
  output logic                      floor_hit,
  output logic [NUM_SHOTS-1:0][9:0] shot_x,
  output logic [NUM_SHOTS-1:0][9:0] shot_y,
  output logic [NUM_SHOTS-1:0]      shot_active,
  output logic                      shot_dropped
);

  localparam logic signed [10:0] SIZE_S = 11'(DOODLE_SIZE);
  localparam logic signed [10:0] GRAV_S = 11'(GRAVITY);
  localparam logic signed [10:0] MAXF_S = 11'(MAX_FALL);
  localparam logic signed [10:0] STEP_S = 11'(MOVE_STEP);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
  localparam logic [9:0] HOME_X    = 10'(SCREEN_CX);
  localparam logic [9:0] HOME_Y    = 10'(SCREEN_CY);
  localparam logic [9:0] FLOOR_Y   = 10'(Y_MAX - DOODLE_SIZE);
  localparam logic [7:0] BOUNCE_VY = 8'(-JUMP_VEL);

  mode_t              modeCur;
  logic signed [10:0] curX, curY, curVy, feet, fallVy, stepX, nextXs;
  logic               landHit, landNow, fireReq;
  logic [IDX_W-1:0]   landSel;
  logic [8:0]         landPlatY;
  logic [9:0]         snapY, fallY, nextX;
  logic [7:0]         prevKey;

  assign modeCur = mode_t'(mode);
  assign curX    = $signed({1'b0, doodle_x});
  assign curY    = $signed({1'b0, doodle_y});
  assign curVy   = {{3{doodle_vy[7]}}, doodle_vy};
  assign feet    = curY + SIZE_S;

  // Pick the lowest-index valid platform whose box contains the feet point
  always_comb begin
    landHit   = 1'b0;
    landSel   = '0;
    landPlatY = '0;
    for (int i = NUM_PLATS - 1; i >= 0; i--) begin
      if (plat_valid[i] &&
          withinTol(feet, $signed({2'b00, plat_y[i]}), plat_half_h) &&
          withinTol(curX, $signed({2'b00, plat_x[i]}), plat_half_w)) begin
        landHit   = 1'b1;
        landSel   = IDX_W'(i);
        landPlatY = plat_y[i];
      end
    end
  end

  // Only a falling character can land; rising through a platform is allowed
  assign landNow = landHit && (curVy > 0);
  assign snapY   = 10'($signed({2'b00, landPlatY}) - $signed({2'b00, plat_half_h}) - SIZE_S);
  assign fallY   = 10'(curY + curVy);
  assign fallVy  = (curVy + GRAV_S > MAXF_S) ? MAXF_S : curVy + GRAV_S;

  // Horizontal step from the held key, wrapping to the opposite edge
  always_comb begin
    stepX = '0;
    if (keycode == KEY_RIGHT_D || keycode == KEY_RIGHT_ARR) stepX = STEP_S;
    else if (keycode == KEY_LEFT_A || keycode == KEY_LEFT_ARR) stepX = -STEP_S;
    nextXs = curX + stepX;
    nextX  = 10'(nextXs);
    if (nextXs > XMAX_S) nextX = 10'(X_MIN);
    else if (nextXs < XMIN_S) nextX = 10'(X_MAX);
  end

  // Fire only on the press edge of the fire key, and only while playing
  assign fireReq = (modeCur == PLAY) && (keycode == KEY_FIRE) && (prevKey != KEY_FIRE);

  // Character state: parked in IDLE, integrated in PLAY, frozen in PAUSE
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      doodle_x   <= HOME_X;
      doodle_y   <= HOME_Y;
      doodle_vy  <= '0;
      landed     <= 1'b0;
      landed_idx <= '0;
      floor_hit  <= 1'b0;
      prevKey    <= '0;
    end else if (modeCur == IDLE) begin
      doodle_x   <= HOME_X;
      doodle_y   <= HOME_Y;
      doodle_vy  <= '0;
      landed     <= 1'b0;
      landed_idx <= '0;
      floor_hit  <= 1'b0;
      prevKey    <= keycode;
    end else if (modeCur == PLAY) begin
      landed    <= 1'b0;
      floor_hit <= 1'b0;
      prevKey   <= keycode;
      doodle_x  <= nextX;
      if (landNow) begin
        doodle_y   <= snapY;
        doodle_vy  <= BOUNCE_VY;
        landed     <= 1'b1;
        landed_idx <= landSel;
      end else if (feet >= YMAX_S) begin
        doodle_y  <= FLOOR_Y;
        doodle_vy <= BOUNCE_VY;
        floor_hit <= 1'b1;
      end else begin
        doodle_y  <= fallY;
        doodle_vy <= 8'(fallVy);
      end
    end else begin
      landed    <= 1'b0;
      floor_hit <= 1'b0;
    end
  end

  shot_pool #(
    .NUM_SHOTS (NUM_SHOTS),
    .SHOT_SPEED(SHOT_SPEED),
    .SHOT_Y_MIN(SHOT_Y_MIN)
  ) u_shot_pool (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .clear       (modeCur == IDLE),
    .run         (modeCur == PLAY),
    .fire        (fireReq),
    .originX     (doodle_x),
    .originY     (doodle_y),
    .shot_x      (shot_x),
    .shot_y      (shot_y),
    .shot_active (shot_active),
    .shot_dropped(shot_dropped)
  );

endmodule

// File: tb/tb_doodle_physics.sv
// Bench for doodle_physics: frame-level behavioural model plus directed scenarios.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Summary line reports total comparisons and failures.
module tb_doodle_physics;

  localparam int NP = 16;
  localparam int NS = 4;

  logic              frame_clk;
  logic              Reset;
  logic [1:0]        mode;
  logic [7:0]        keycode;
  logic [NP-1:0][8:0] plat_x, plat_y;
  logic [NP-1:0]     plat_valid;
  logic [8:0]        plat_half_w, plat_half_h;
  logic [9:0]        doodle_x, doodle_y;
  logic [7:0]        doodle_vy;
  logic              landed, floor_hit, shot_dropped;
  logic [3:0]        landed_idx;
  logic [NS-1:0][9:0] shot_x, shot_y;
  logic [NS-1:0]     shot_active;

  doodle_physics dut (
    .frame_clk(frame_clk), .Reset(Reset), .mode(mode), .keycode(keycode),
    .plat_x(plat_x), .plat_y(plat_y), .plat_valid(plat_valid),
    .plat_half_w(plat_half_w), .plat_half_h(plat_half_h),
    .doodle_x(doodle_x), .doodle_y(doodle_y), .doodle_vy(doodle_vy),
    .landed(landed), .landed_idx(landed_idx), .floor_hit(floor_hit),
    .shot_x(shot_x), .shot_y(shot_y), .shot_active(shot_active),
    .shot_dropped(shot_dropped)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame-level, plain integers) ----------------
  int mX, mY, mVy, mIdx, mPrev;
  bit mLand, mFloor, mDrop;
  int sX[NS], sY[NS];
  bit sAct[NS];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic modelPark();
    mX = 320; mY = 240; mVy = 0; mIdx = 0;
    mLand = 0; mFloor = 0; mDrop = 0;
    for (int i = 0; i < NS; i++) begin
      sX[i] = 320; sY[i] = 240; sAct[i] = 0;
    end
  endtask

  task automatic modelStep();
    int feet, hit, nx, step, freeSlot;
    bit fire;
    bit wasAct[NS];
    if (mode == 2'b00) begin
      modelPark();
      mPrev = keycode;
      return;
    end
    mLand = 0; mFloor = 0; mDrop = 0;
    if (mode != 2'b01) return;
    // vertical
    feet = mY + 6;
    hit  = -1;
    for (int i = 0; i < NP; i++)
      if (hit < 0 && mVy > 0 && plat_valid[i] &&
          iabs(feet - int'(plat_y[i])) <= int'(plat_half_h) &&
          iabs(mX - int'(plat_x[i])) <= int'(plat_half_w))
        hit = i;
    // horizontal (uses the pre-frame x, like the landing test)
    step = 0;
    if (keycode == 7 || keycode == 79) step = 2;
    else if (keycode == 4 || keycode == 80) step = -2;
    nx = mX + step;
    if (nx > 614) nx = 25;
    else if (nx < 25) nx = 614;
    // shots use the pre-frame character position
    fire = (keycode == 30) && (mPrev != 30);
    freeSlot = -1;
    for (int i = 0; i < NS; i++) begin
      wasAct[i] = sAct[i];
      if (freeSlot < 0 && !sAct[i]) freeSlot = i;
    end
    for (int i = 0; i < NS; i++)
      if (wasAct[i]) begin
        if (sY[i] <= 32) sAct[i] = 0;
        sY[i] = (sY[i] - 7) & 1023;
      end
    if (fire) begin
      if (freeSlot >= 0) begin
        sX[freeSlot] = mX; sY[freeSlot] = mY; sAct[freeSlot] = 1;
      end else mDrop = 1;
    end
    if (hit >= 0) begin
      mY = int'(plat_y[hit]) - int'(plat_half_h) - 6; mVy = -12; mLand = 1; mIdx = hit;
    end else if (feet >= 479) begin
      mY = 473; mVy = -12; mFloor = 1;
    end else begin
      mY = mY + mVy; mVy = (mVy + 1 > 10) ? 10 : mVy + 1;
    end
    mX = nx;
    mPrev = keycode;
  endtask

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      modelPark();
      mPrev = 0;
    end else modelStep();
  end

  // Compare every output against the model on each falling edge
  always @(negedge frame_clk) begin
    if (checkOn) begin
      check("m_doodle_x", doodle_x, mX);
      check("m_doodle_y", doodle_y, mY);
      check("m_doodle_vy", $signed(doodle_vy), mVy);
      check("m_landed", landed, mLand);
      if (mLand) check("m_landed_idx", landed_idx, mIdx);
      check("m_floor_hit", floor_hit, mFloor);
      check("m_shot_dropped", shot_dropped, mDrop);
      for (int i = 0; i < NS; i++) begin
        check($sformatf("m_shot_active[%0d]", i), shot_active[i], sAct[i]);
        check($sformatf("m_shot_x[%0d]", i), shot_x[i], sX[i]);
        check($sformatf("m_shot_y[%0d]", i), shot_y[i], sY[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic frames(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  int expY, expVy;

  initial begin
    Reset = 1'b0; mode = 2'b00; keycode = 8'd0;
    plat_x = '0; plat_y = '0; plat_valid = '0;
    plat_half_w = 9'd20; plat_half_h = 9'd4;
    #1 Reset = 1'b1;
    frames(2);
    Reset = 1'b0;
    checkOn = 1'b1;
    check("rst_x", doodle_x, 320);
    check("rst_y", doodle_y, 240);
    check("rst_vy", doodle_vy, 0);
    check("rst_pulses", {landed, floor_hit, shot_dropped}, 0);
    check("rst_idx", landed_idx, 0);
    check("rst_active", shot_active, 0);
    check("rst_shot_x0", shot_x[0], 320);
    check("rst_shot_y3", shot_y[3], 240);

    // Free fall: vy ramps 1..10 then saturates
    mode = 2'b01;
    expY = 240; expVy = 0;
    for (int k = 1; k <= 20; k++) begin
      expY += expVy;
      expVy = (expVy + 1 > 10) ? 10 : expVy + 1;
      frames(1);
      check("fall_y", doodle_y, expY);
      check("fall_vy", $signed(doodle_vy), expVy);
    end
    check("fall_y_end", doodle_y, 385);

    // IDLE parks the character
    mode = 2'b00;
    frames(1);
    check("idle_y", doodle_y, 240);
    check("idle_vy", doodle_vy, 0);

    // Single platform landing: platform 3 at (320,258)
    plat_x[3] = 9'd320; plat_y[3] = 9'd258; plat_valid[3] = 1'b1;
    mode = 2'b01;
    frames(5);
    check("pre_land_y", doodle_y, 250);
    check("pre_land_vy", $signed(doodle_vy), 5);
    frames(1);
    check("land_pulse", landed, 1);
    check("land_idx", landed_idx, 3);
    check("land_y", doodle_y, 248);
    check("land_vy", $signed(doodle_vy), -12);
    frames(1);
    check("land_pulse_clear", landed, 0);
    frames(4);
    check("rise_y", doodle_y, 198);
    check("rise_vy", $signed(doodle_vy), -7);

    // Pause freezes everything including vy
    mode = 2'b10;
    frames(3);
    mode = 2'b11;
    frames(2);
    check("pause_y", doodle_y, 198);
    check("pause_vy", $signed(doodle_vy), -7);
    mode = 2'b01;
    frames(1);
    check("resume_y", doodle_y, 191);
    check("resume_vy", $signed(doodle_vy), -6);

    // Asynchronous reset during pause
    mode = 2'b10;
    frames(1);
    #2 Reset = 1'b1;
    #1;
    check("arst_x", doodle_x, 320);
    check("arst_y", doodle_y, 240);
    check("arst_vy", doodle_vy, 0);
    check("arst_active", shot_active, 0);
    frames(1);
    Reset = 1'b0;

    // Two overlapping platforms: lower index wins
    mode = 2'b00; plat_valid = '0;
    frames(1);
    plat_x[2] = 9'd320; plat_y[2] = 9'd258;
    plat_x[5] = 9'd318; plat_y[5] = 9'd257;
    plat_valid[2] = 1'b1; plat_valid[5] = 1'b1;
    mode = 2'b01;
    frames(6);
    check("dual_land", landed, 1);
    check("dual_idx", landed_idx, 2);
    check("dual_y", doodle_y, 248);

    // Horizontal wrap in both directions (vertical tracked by the model)
    mode = 2'b00; plat_valid = '0;
    frames(1);
    mode = 2'b01; keycode = 8'd7;
    frames(147);
    check("edge_x", doodle_x, 614);
    frames(1);
    check("wrap_right_x", doodle_x, 25);
    keycode = 8'd80;
    frames(1);
    check("wrap_left_x", doodle_x, 614);
    keycode = 8'd4;
    frames(1);
    check("step_left_x", doodle_x, 612);
    keycode = 8'd0;

    // Firing: held key fires once
    mode = 2'b00;
    frames(1);
    mode = 2'b01; keycode = 8'd30;
    frames(10);
    check("hold_active", shot_active, 4'b0001);
    check("hold_shot_x", shot_x[0], 320);
    check("hold_shot_y", shot_y[0], 177);
    for (int p = 0; p < 3; p++) begin
      keycode = 8'd0;  frames(1);
      keycode = 8'd30; frames(1);
    end
    check("full_active", shot_active, 4'b1111);
    keycode = 8'd0;  frames(1);
    keycode = 8'd30; frames(1);
    check("drop_pulse", shot_dropped, 1);
    frames(1);
    check("drop_clear", shot_dropped, 0);

    // Let shots retire while pressing periodically; model covers reuse
    for (int r = 0; r < 40; r++) begin
      keycode = (r % 3 == 0) ? 8'd30 : 8'd0;
      frames(1);
    end
    keycode = 8'd0;
    mode = 2'b00;
    frames(1);
    check("idle_clears_shots", shot_active, 0);

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
